// File: rtl/camera_bayer_pkg.sv
// Shared widths, FSM state type, colour-bar table and quad-to-RGB565 maths
// for the Bayer packer.
package camera_bayer_pkg;

  localparam int unsigned RGB565_W = 16;
  localparam int unsigned OUT_W    = 32;
  localparam int unsigned RAW_W    = 12;

  typedef enum logic [1:0] {
    IDLE,
    ROW_EVEN,
    ROW_ODD
  } state_t;

  // Index 0..7 = white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][RGB565_W-1:0] COLOUR_BARS = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  // Green is the 13-bit sum of both greens, keeping its top 6 bits.
  function automatic logic [RGB565_W-1:0] bayer_to_rgb565(
    input logic [RAW_W-1:0] g1,
    input logic [RAW_W-1:0] r,
    input logic [RAW_W-1:0] b,
    input logic [RAW_W-1:0] g2
  );
    logic [RAW_W:0] g_sum;
    g_sum = {1'b0, g1} + {1'b0, g2};
    return {r[RAW_W-1 -: 5], g_sum[RAW_W -: 6], b[RAW_W-1 -: 5]};
  endfunction

endpackage

// File: rtl/camera_line_buffer.sv
// One-line store of {G1,R} pairs: single write port, single synchronous read
// port, no reset on the array so it maps onto block RAM.
module camera_line_buffer #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/camera_bayer_rgb565.sv
// Collapses 2x2 Bayer quads (G1 R / B G2) into RGB565 and packs two pixels per
// 32-bit valid/ready word. Define CAM_BAYER_TEST_PATTERN_EN to add test_mode.
module camera_bayer_rgb565
  import camera_bayer_pkg::*;
#(
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned LINES  = 480
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eol,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_sof,
  input  logic             out_ready,
`ifdef CAM_BAYER_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic             frame_done,
  output logic             sync_err
);

  localparam int unsigned COL_W = $clog2(LINE_W);
  localparam int unsigned ROW_W = $clog2(LINES);
  localparam int unsigned BUF_D = LINE_W / 2;
  localparam int unsigned BUF_W = 2 * PIX_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES - 1);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PIX_W-1:0]    g1_q, g1_d, b_q, b_d;
  logic [RGB565_W-1:0] hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                sof_pend_q, sof_pend_d;
  logic                last_q, last_d;
  logic [OUT_W-1:0]    data_d;
  logic                valid_d, osof_d, err_d;
  logic                take, col_last, line_end;
  logic                wr_en, rd_en;
  logic [BUF_W-1:0]    rd_pair;
  logic [RGB565_W-1:0] quad_rgb, pix_rgb;

  // Odd rows complete words, so only they must wait for a full output register.
  assign in_ready   = !((state_q == ROW_ODD) && out_valid && !out_ready);
  assign take       = in_valid && in_ready;
  assign col_last   = (col_q == COL_LAST);
  assign line_end   = in_eol || col_last;
  assign frame_done = out_valid && out_ready && last_q;

  camera_line_buffer #(
    .DEPTH (BUF_D),
    .WIDTH (BUF_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (col_q[COL_W-1:1]),
    .wr_data ({g1_q, in_data}),
    .rd_en   (rd_en),
    .rd_addr (col_q[COL_W-1:1]),
    .rd_data (rd_pair)
  );

  assign quad_rgb = bayer_to_rgb565(rd_pair[BUF_W-1 -: RAW_W], rd_pair[PIX_W-1 -: RAW_W],
                                    b_q[PIX_W-1 -: RAW_W], in_data[PIX_W-1 -: RAW_W]);

`ifdef CAM_BAYER_TEST_PATTERN_EN
  logic [2:0] bar;
  // bar = c*8/(LINE_W/2) with c the output column
  assign bar     = 3'((32'(col_q[COL_W-1:1]) * 32'd16) / 32'(LINE_W));
  assign pix_rgb = test_mode ? COLOUR_BARS[bar] : quad_rgb;
`else
  assign pix_rgb = quad_rgb;
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    g1_d       = g1_q;
    b_d        = b_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sof_pend_d = sof_pend_q;
    last_d     = last_q;
    data_d     = out_data;
    valid_d    = out_valid;
    osof_d     = out_sof;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    if (out_valid && out_ready) begin
      valid_d = 1'b0;
      osof_d  = 1'b0;
      last_d  = 1'b0;
    end

    if (take) begin
      if (in_sof) begin
        // Restart at row 0 col 0; a held output word is left untouched.
        err_d      = (state_q != IDLE);
        state_d    = ROW_EVEN;
        col_d      = COL_W'(1);
        row_d      = '0;
        g1_d       = in_data;
        hold_vld_d = 1'b0;
        sof_pend_d = 1'b1;
      end else if (state_q != IDLE) begin
        if (state_q == ROW_EVEN) begin
          if (!col_q[0]) g1_d = in_data;
          else           wr_en = 1'b1;
        end else if (!col_q[0]) begin
          b_d   = in_data;
          rd_en = 1'b1;
        end else if (!col_q[1]) begin
          hold_d     = pix_rgb;
          hold_vld_d = 1'b1;
        end else if (hold_vld_q) begin
          data_d     = {pix_rgb, hold_q};
          valid_d    = 1'b1;
          osof_d     = sof_pend_q;
          sof_pend_d = 1'b0;
          last_d     = (row_q == ROW_LAST) && col_last;
        end

        col_d = col_q + COL_W'(1);
        if (line_end) begin
          err_d      = in_eol ^ col_last;
          col_d      = '0;
          hold_vld_d = 1'b0;
          row_d      = row_q + ROW_W'(1);
          if (state_q == ROW_EVEN) begin
            state_d = ROW_ODD;
          end else if (row_q == ROW_LAST) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            state_d = ROW_EVEN;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      g1_q       <= '0;
      b_q        <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sof_pend_q <= 1'b0;
      last_q     <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      g1_q       <= g1_d;
      b_q        <= b_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sof_pend_q <= sof_pend_d;
      last_q     <= last_d;
      out_data   <= data_d;
      out_valid  <= valid_d;
      out_sof    <= osof_d;
      sync_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_camera_bayer_rgb565.sv
// Randomized bench for camera_bayer_rgb565 on a small 8x4 raw frame, scored
// against a frame-level quad model.
`timescale 1ns/1ps
module tb_camera_bayer_rgb565;

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned LINE_W = 8;
  localparam int unsigned LINES  = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [PIX_W-1:0] in_data;
  logic             in_valid, in_sof, in_eol, in_ready;
  logic [31:0]      out_data;
  logic             out_valid, out_sof, out_ready;
  logic             frame_done, sync_err;
`ifdef CAM_BAYER_TEST_PATTERN_EN
  logic             test_mode = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    sync_err_cnt = 0;
  int    frame_done_cnt = 0;
  int    stall_left = 0;
  int    stall_at = -1;
  int    stall_low_seen = 0;
  bit    rand_ready = 1'b0;
  bit    rand_gap = 1'b0;
  int    pix [LINES][LINE_W];
  int    len [LINES];
  bit    noeol [LINES];

  always #5 clk = ~clk;

  camera_bayer_rgb565 #(.PIX_W(PIX_W), .LINE_W(LINE_W), .LINES(LINES)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_eol     (in_eol),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_ready  (out_ready),
`ifdef CAM_BAYER_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream readiness: forced stall window, else random or always ready.
  always @(negedge clk) begin
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (sync_err) sync_err_cnt++;
      if (stall_left > 0 && !in_ready) stall_low_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          if (out_ready) check_eq("unexpected_word", 32'(out_valid), 32'd0);
        end else begin
          check_eq("word_data", out_data, exp_q[0].data);
          if (out_ready) begin
            check_eq("word_sof", 32'(out_sof), 32'(exp_q[0].sof));
            check_eq("frame_done", 32'(frame_done), 32'(exp_q[0].last));
            if (frame_done) frame_done_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end else if (frame_done) begin
        check_eq("frame_done_stray", 32'(frame_done), 32'd0);
      end
    end
  end

  function automatic int quad_rgb(input int p, input int k);
    int g1, r, b, g2;
    g1 = pix[2*p][2*k];
    r  = pix[2*p][2*k+1];
    b  = pix[2*p+1][2*k];
    g2 = pix[2*p+1][2*k+1];
    return ((r / 128) * 2048) + (((g1 + g2) / 128) * 32) + (b / 128);
  endfunction

  task automatic fill_frame(input int mode);
    for (int r = 0; r < LINES; r++) begin
      len[r]   = LINE_W;
      noeol[r] = 1'b0;
      for (int c = 0; c < LINE_W; c++) begin
        case (mode)
          0:       pix[r][c] = 'hFFF;
          1:       pix[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? 'h800 : 'hF80)
                                            : ((c % 2 == 0) ? 'h080 : 'h800);
          default: pix[r][c] = int'($urandom_range(0, 4095));
        endcase
      end
    end
  endtask

  // A word exists for each pair of quads fully received on an odd row.
  task automatic expect_frame(input int abort_row, input int abort_col);
    bit first;
    int odd, n;
    word_t e;
    first = 1'b1;
    for (int p = 0; p < LINES / 2; p++) begin
      odd = 2 * p + 1;
      if (odd == abort_row)     n = abort_col;
      else if (odd > abort_row) n = 0;
      else                      n = len[odd];
      for (int w = 0; 4 * w + 3 < n; w++) begin
        e.data = {16'(quad_rgb(p, 2 * w + 1)), 16'(quad_rgb(p, 2 * w))};
        e.sof  = first;
        e.last = (odd == LINES - 1) && (4 * w + 3 == LINE_W - 1);
        first  = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input int px, input bit sof, input bit eol);
    int waits;
    waits = 0;
    if (rand_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_data  = PIX_W'(px);
    in_sof   = sof;
    in_eol   = eol;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waits < 500) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic drive_frame(input int abort_row, input int abort_col);
    int n;
    for (int r = 0; r < LINES; r++) begin
      if (r > abort_row) break;
      n = (r == abort_row) ? abort_col : len[r];
      for (int c = 0; c < n; c++) begin
        if (r * LINE_W + c == stall_at) stall_left = 20;
        send(pix[r][c], (r == 0) && (c == 0), (c == n - 1) && (r != abort_row) && !noeol[r]);
      end
    end
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("drain_words_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int exp_sync, input int exp_fd);
    int s0, f0;
    s0 = sync_err_cnt;
    f0 = frame_done_cnt;
    expect_frame(LINES, 0);
    drive_frame(LINES, 0);
    wait_drain();
    check_eq({tag, "_sync_err"}, 32'(sync_err_cnt - s0), 32'(exp_sync));
    check_eq({tag, "_frame_done"}, 32'(frame_done_cnt - f0), 32'(exp_fd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_sof"}, 32'(out_sof), 32'd0);
    check_eq({tag, "_out_data"}, out_data, 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send_stray(input string tag);
    int s0;
    s0 = sync_err_cnt;
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 4095)), 1'b0, i == 2);
    repeat (4) @(negedge clk);
    #2;
    check_eq({tag, "_no_output"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_no_sync_err"}, 32'(sync_err_cnt - s0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset_n  = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    send_stray("idle");

    fill_frame(0);
    run_frame("flat", 0, 1);

    fill_frame(1);
    run_frame("quad", 0, 1);

    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fill_frame(2);
      run_frame("random", 0, 1);
    end
    rand_ready = 1'b0;
    rand_gap   = 1'b0;

    fill_frame(2);
    stall_low_seen = 0;
    stall_at = LINE_W + 3;
    run_frame("stall", 0, 1);
    stall_at = -1;
    check_eq("stall_in_ready_low", 32'(stall_low_seen > 0), 32'd1);

    fill_frame(2);
    len[1] = 6;
    run_frame("early_eol", 1, 1);

    fill_frame(2);
    noeol[3] = 1'b1;
    run_frame("missing_eol", 1, 1);

    // Frame cut at row 2 col 3 by a new in_sof
    fill_frame(2);
    s0 = sync_err_cnt;
    expect_frame(2, 3);
    drive_frame(2, 3);
    fill_frame(2);
    run_frame("sof_restart", 1, 1);
    check_eq("sof_restart_total_sync_err", 32'(sync_err_cnt - s0), 32'd1);

    // Reset while a finished word is held by a stalled sink
    fill_frame(2);
    stall_left = 40;
    expect_frame(1, 4);
    drive_frame(1, 4);
    repeat (2) @(negedge clk);
    #2;
    check_eq("pending_before_reset", 32'(out_valid), 32'd1);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    stall_left = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    send_stray("post_reset");

    fill_frame(2);
    run_frame("after_reset", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_bayer_rgb565.md
Name: camera_bayer_rgb565

Overview:
- Debayer/pack stage between the camera capture front end (12-bit raw Bayer pixels, already in the system clock domain) and the frame-buffer DMA writer that fills DDR for the LCD controller.
- Collapses each 2x2 Bayer quad (G1 R / B G2) into one RGB565 pixel.
- Packs two RGB565 pixels per 32-bit word and emits them on a valid/ready stream.
- Output frame is LINE_W/2 x LINES/2 pixels (320x240 at defaults).

Parameters:
- PIX_W, 12: raw pixel width.
- LINE_W, 640: raw pixels per line; must be a multiple of 4.
- LINES, 480: raw lines per frame; must be even.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  PIX_W  raw Bayer pixel.
- in_valid  in  1  in_data valid.
- in_sof  in  1  qualifies the first pixel of a frame.
- in_eol  in  1  qualifies the last pixel of a line.
- in_ready  out  1  stage accepts a pixel this cycle.
- out_data  out  32  [15:0] first pixel, [31:16] second pixel; each RGB565 {R5,G6,B5}.
- out_valid  out  1  out_data valid.
- out_sof  out  1  qualifies the first word of a frame.
- out_ready  in  1  downstream accepts.
- frame_done  out  1  one-cycle pulse when the last word of a frame is accepted.
- sync_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Handshakes
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - out_data and out_sof stay stable while out_valid & !out_ready.
- Reset
  - State IDLE; all counters 0.
  - out_valid, out_sof, frame_done, sync_err are 0; out_data is 0.
  - in_ready is 1.
- FSM states
  - IDLE
    - Pixels are dropped until in_sof is seen.
    - A pixel carrying in_sof is taken as column 0 of row 0 and moves the FSM to ROW_EVEN.
  - ROW_EVEN
    - Pixels pair as G1,R.
    - Each pair is written as 24 bits {G1,R} to the line buffer at col/2.
    - in_ready is held at 1.
    - An in_eol pixel moves the FSM to ROW_ODD.
  - ROW_ODD
    - Pixels pair as B,G2.
    - The buffer is read at col/2 when B is accepted; synchronous read data is used when G2 is accepted.
    - in_ready = !(out_valid & !out_ready).
    - An in_eol pixel moves the FSM to ROW_EVEN.
    - If that line was raw line LINES-1, the FSM moves to IDLE instead.
- Arithmetic
  - R5 = R[11:7].
  - G6 = (G1+G2)[12:7], with a 13-bit sum.
  - B5 = B[11:7].
- Packing
  - Even pixel index goes to a holding register.
  - Odd pixel index completes the word.
  - out_valid rises on the cycle after the accepting G2 edge of every 4th odd-row pixel.
  - Latency from that input acceptance to out_valid is 1 cycle.
- out_sof is 1 on the first word of row pair 0.
- frame_done pulses on the cycle the final word (row LINES-1, last column) transfers.
- Column counter
  - 0..LINE_W-1.
  - If it reaches LINE_W-1 without in_eol: treat the pixel as end of line and pulse sync_err.
  - If in_eol arrives early: pulse sync_err, discard any partial word, advance row.
- in_sof outside IDLE: pulse sync_err, discard the partial word, restart at row 0 col 0 with that pixel. A held output word is still delivered.
- Simultaneous in_sof & in_eol on one pixel: in_sof wins.
- Reset mid-frame: everything is discarded immediately, including any pending output word.
- Line buffer: LINE_W/2 x 24-bit single-port-write, single-port-read RAM; contents are not reset.

Optional Feature:
- Macro: CAM_BAYER_TEST_PATTERN_EN.
- Defined
  - Adds input port test_mode (1 bit).
  - When test_mode=1, the pixel value is replaced by colour bars: out column index c (0..LINE_W/2-1) -> bar = c*8/(LINE_W/2), mapped to {white,yellow,cyan,green,magenta,red,blue,black}.
  - Handshake, timing and framing are unchanged; input is still consumed.
- Undefined: no port, no logic.

Decomposition:
- Package camera_bayer_pkg holds:
  - localparams RGB565_W=16 and OUT_W=32;
  - state enum {IDLE, ROW_EVEN, ROW_ODD};
  - function bayer_to_rgb565(g1, r, b, g2);
  - colour-bar constant table.
- Sub-module camera_line_buffer: a parameterised depth x width RAM with synchronous read, inferable as M10K.

Test Plan:
- Flat frame, LINE_W=8, LINES=4, all pixels 12'hFFF, out_ready=1.
  - 4 words, all 32'hFFFF_FFFF.
  - out_sof on word 0 only.
  - frame_done on word 3.
- Quad values G1=12'h800, R=12'hF80, B=12'h080, G2=12'h800.
  - Each RGB565 = {5'h1F, 6'h20, 5'h01} = 16'hFC01.
  - Words = 32'hFC01_FC01.
- out_ready held 0 for 20 cycles mid odd row.
  - in_ready drops after the next completed word.
  - out_data stays stable.
  - No pixel is lost; word count is correct after release.
- in_eol on column 5 of a LINE_W=8 row.
  - sync_err pulses once.
  - Partial word is discarded.
  - Next row starts at col 0 with correct row parity.
- in_sof asserted at row 2 col 3.
  - sync_err pulses.
  - Next output word carries out_sof.
  - A full frame follows with frame_done.
- reset_n asserted mid-word, then released.
  - All outputs 0.
  - Pixels are ignored until the next in_sof.
